// File: rtl/fetch_unit.sv
// Instruction fetch unit: a three-state IDLE/FETCH/ISSUE sequencer that reads
// one word from instruction memory, holds it for issue, then computes the next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel_bit_PC,
  input  logic [31:0] jump_offset,
  input  logic [31:0] branch_offset,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  OPcode,
  output logic [2:0]  func3,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] instr_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_offset;
  logic [31:0] pc_target;
  logic [31:0] next_pc;

  // Next-PC is relative to the issued instruction; selector 11 falls back to sequential.
  always_comb begin
    pc_offset = 32'd4;
    case (sel_bit_PC)
      2'b01:   pc_offset = jump_offset;
      2'b10:   pc_offset = branch_offset;
      default: pc_offset = 32'd4;
    endcase
    pc_target = pc_out + pc_offset;
    next_pc   = pc_target & PC_ALIGN_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC_ALIGNED;
      instr       <= 32'd0;
      pc_out      <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            instr  <= imem_rdata;
            pc_out <= pc;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_count <= instr_count + 32'd1;
            state       <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode straight from state so reset drops them without a clock.
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == ISSUE);
  assign imem_addr   = pc;
  assign OPcode      = instr[6:0];
  assign func3       = instr[14:12];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a table of fetch/issue/retire vectors with a scoreboard
// of expected issued instructions, plus a hand-written mid-fetch reset sequence.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  sel_bit_PC;
  logic [31:0] jump_offset;
  logic [31:0] branch_offset;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  OPcode;
  logic [2:0]  func3;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] instr_count;

  typedef struct {
    int          ack_delay;
    logic [31:0] rdata;
    logic [1:0]  sel;
    logic [31:0] jump_off;
    logic [31:0] branch_off;
    logic [31:0] exp_next;
    int          stall_cycles;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] count;
  } exp_t;

  vec_t        vecs [10];
  exp_t        sb [$];
  logic [31:0] model_pc;
  logic [31:0] model_count;
  int          checks;
  int          errors;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .sel_bit_PC    (sel_bit_PC),
    .jump_offset   (jump_offset),
    .branch_offset (branch_offset),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .OPcode        (OPcode),
    .func3         (func3),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .instr_count   (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkIssued(input exp_t e);
    logic [31:0] exp_instr;
    logic [6:0]  exp_op;
    logic [2:0]  exp_f3;
    exp_instr = e.instr;
    exp_op    = exp_instr[6:0];
    exp_f3    = exp_instr[14:12];
    checkOutput("instr",       instr,                 exp_instr);
    checkOutput("OPcode",      {25'd0, OPcode},       {25'd0, exp_op});
    checkOutput("func3",       {29'd0, func3},        {29'd0, exp_f3});
    checkOutput("pc_out",      pc_out,                e.pc);
    checkOutput("instr_count", instr_count,           e.count);
    checkOutput("instr_valid", {31'd0, instr_valid},  32'd1);
    checkOutput("issue_req",   {31'd0, imem_req},     32'd0);
  endtask

  // One full fetch/issue/retire round; called on a falling edge.
  task automatic applyStimulus(input vec_t v);
    int   n;
    exp_t e;
    n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      checkOutput("imem_req_timeout", {31'd0, imem_req}, 32'd1);
      return;
    end
    checkOutput("imem_addr", imem_addr, model_pc);
    imem_ack = 1'b0;
    for (int d = 0; d < v.ack_delay; d++) begin
      @(negedge clk);
      checkOutput("addr_stable", imem_addr, model_pc);
      checkOutput("req_held", {31'd0, imem_req}, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    sb.push_back('{instr: v.rdata, pc: model_pc, count: model_count});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    e = sb.pop_front();
    checkIssued(e);
    for (int s = 0; s < v.stall_cycles; s++) begin
      stall      = 1'b1;
      sel_bit_PC = 2'(s + 1);
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_0000 | 32'(s);
      @(negedge clk);
      checkIssued(e);
    end
    stall         = 1'b0;
    imem_ack      = 1'b0;
    sel_bit_PC    = v.sel;
    jump_offset   = v.jump_off;
    branch_offset = v.branch_off;
    @(negedge clk);
    model_pc    = v.exp_next;
    model_count = model_count + 32'd1;
    checkOutput("retire_count", instr_count, model_count);
    checkOutput("retire_valid", {31'd0, instr_valid}, 32'd0);
    sel_bit_PC = 2'b00;
  endtask

  initial begin
    vec_t restart;
    checks        = 0;
    errors        = 0;
    model_pc      = 32'h0;
    model_count   = 32'h0;
    rst           = 1'b1;
    sel_bit_PC    = 2'b00;
    jump_offset   = 32'h0;
    branch_offset = 32'h0;
    stall         = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;

    vecs[0] = '{3, 32'h0000_0033, 2'b00, 32'h0,         32'h0,         32'h0000_0004, 0};
    vecs[1] = '{0, 32'h00A2_8293, 2'b01, 32'h0000_000C, 32'h0,         32'h0000_0010, 1};
    vecs[2] = '{2, 32'h00C5_1463, 2'b01, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008, 0};
    vecs[3] = '{1, 32'h0021_2023, 2'b10, 32'h0,         32'h0000_0018, 32'h0000_0020, 0};
    vecs[4] = '{0, 32'h00B5_0533, 2'b10, 32'h0,         32'h0000_0013, 32'h0000_0030, 5};
    vecs[5] = '{1, 32'hFE00_0EE3, 2'b01, 32'hFFFF_FFF0, 32'h0,         32'h0000_0020, 0};
    vecs[6] = '{0, 32'h0000_4003, 2'b11, 32'h0000_0100, 32'h0000_0200, 32'h0000_0024, 0};
    vecs[7] = '{2, 32'h0080_006F, 2'b01, 32'hFFFF_FFD8, 32'h0,         32'hFFFF_FFFC, 0};
    vecs[8] = '{1, 32'h0000_7013, 2'b00, 32'h0,         32'h0,         32'h0000_0000, 2};
    vecs[9] = '{0, 32'h0000_5093, 2'b10, 32'h0,         32'h0000_0040, 32'h0000_0040, 0};

    repeat (2) @(negedge clk);
    checkOutput("rst_req",   {31'd0, imem_req},    32'd0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_addr",  imem_addr,            32'h0);
    checkOutput("rst_instr", instr,                32'h0);
    checkOutput("rst_count", instr_count,          32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset lands asynchronously in the middle of a fetch at 0x40.
    checkOutput("pre_reset_addr", imem_addr, 32'h0000_0040);
    checkOutput("pre_reset_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_req",    {31'd0, imem_req},    32'd0);
    checkOutput("async_valid",  {31'd0, instr_valid}, 32'd0);
    checkOutput("async_instr",  instr,                32'h0);
    checkOutput("async_pc_out", pc_out,               32'h0);
    checkOutput("async_count",  instr_count,          32'h0);
    checkOutput("async_addr",   imem_addr,            32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    checkOutput("restart_instr", instr,                32'h0);
    checkOutput("restart_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("restart_addr",  imem_addr,            32'h0);
    model_pc    = 32'h0;
    model_count = 32'h0;
    restart = '{1, 32'h0000_0013, 2'b00, 32'h0, 32'h0, 32'h0000_0004, 0};
    applyStimulus(restart);
    checkOutput("restart_next_addr", imem_addr, 32'h0000_0004);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
